// File: rtl/load_store_sequencer_pkg.sv
// Shared constants for the load/store sequencer: memory op sizes, memory
// fault codes (numerically equal to RISC-V mcause) and sequencer states.
package load_store_sequencer_pkg;

  localparam logic [1:0] MEM_OP_SIZE_BYTE    = 2'b00;
  localparam logic [1:0] MEM_OP_SIZE_HALF    = 2'b01;
  localparam logic [1:0] MEM_OP_SIZE_WORD    = 2'b10;
  localparam logic [1:0] MEM_OP_SIZE_INVALID = 2'b11;

  localparam logic [2:0] MEM_FAULT_NUM_NONE             = 3'b000;
  localparam logic [2:0] MEM_FAULT_NUM_LOAD_MISALIGNED  = 3'b100;
  localparam logic [2:0] MEM_FAULT_NUM_LOAD_ACCESS      = 3'b101;
  localparam logic [2:0] MEM_FAULT_NUM_STORE_MISALIGNED = 3'b110;
  localparam logic [2:0] MEM_FAULT_NUM_STORE_ACCESS     = 3'b111;

  typedef enum logic [1:0] {
    SEQ_IDLE    = 2'b00,
    SEQ_ACCESS  = 2'b01,
    SEQ_SAMPLE  = 2'b10,
    SEQ_RESPOND = 2'b11
  } seq_state_t;

  // Any code with bit 2 set is a fault; zero means a clean access.
  function automatic logic is_fault(input logic [2:0] fault_num);
    return fault_num[2];
  endfunction

endpackage

// File: rtl/load_store_sequencer_agu.sv
// Address generation: 32-bit base plus sign-extended 12-bit offset,
// wrapping modulo 2^32 (no overflow detection).
module lsu_agu (
  input  logic [31:0] base,
  input  logic [11:0] offset,
  output logic [31:0] addr
);

  logic [31:0] offset_ext;

  // Sign-extend the immediate and add; carry out is intentionally dropped.
  always_comb begin
    offset_ext = {{20{offset[11]}}, offset};
    addr       = base + offset_ext;
  end

endmodule

// File: rtl/load_store_sequencer.sv
// Load/store sequencer: accepts one request from execute, drives the memory
// access unit for exactly one enabled cycle, samples its registered result
// and fault, and returns a response to writeback.
// Optional macro LSU_FAULT_ADDR_EN adds rsp_fault_addr (mtval source).
module load_store_sequencer
  import load_store_sequencer_pkg::*;
#(
  parameter int unsigned TAG_BITS = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_is_write,
  input  logic                req_is_unsigned,
  input  logic [1:0]          req_op_size,
  input  logic [31:0]         req_base,
  input  logic [11:0]         req_offset,
  input  logic [31:0]         req_wdata,
  input  logic [TAG_BITS-1:0] req_tag,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_data,
  output logic [TAG_BITS-1:0] rsp_tag,
  output logic [2:0]          rsp_fault_num,
`ifdef LSU_FAULT_ADDR_EN
  output logic [31:0]         rsp_fault_addr,
`endif
  output logic                mem_enable_n,
  output logic                mem_is_write,
  output logic                mem_is_unsigned,
  output logic [1:0]          mem_op_size,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_in,
  input  logic [31:0]         mem_out,
  input  logic [2:0]          mem_fault_num
);

  seq_state_t state, state_next;

  logic                accept;
  logic                sample;
  logic [31:0]         agu_addr;

  logic                lat_is_write;
  logic                lat_is_unsigned;
  logic [1:0]          lat_op_size;
  logic [31:0]         lat_addr;
  logic [31:0]         lat_wdata;
  logic [TAG_BITS-1:0] lat_tag;

  logic [31:0]         rsp_data_q;
  logic [2:0]          rsp_fault_q;
  logic [TAG_BITS-1:0] rsp_tag_q;

  lsu_agu u_agu (
    .base   (req_base),
    .offset (req_offset),
    .addr   (agu_addr)
  );

  // State register; async reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SEQ_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake/enable decode from the current state only.
  always_comb begin
    state_next   = state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    mem_enable_n = 1'b1;
    accept       = 1'b0;
    sample       = 1'b0;
    unique case (state)
      SEQ_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          state_next = SEQ_ACCESS;
        end
      end
      SEQ_ACCESS: begin
        mem_enable_n = 1'b0;
        state_next   = SEQ_SAMPLE;
      end
      SEQ_SAMPLE: begin
        sample     = 1'b1;
        state_next = SEQ_RESPOND;
      end
      SEQ_RESPOND: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = SEQ_IDLE;
        end
      end
      default: state_next = SEQ_IDLE;
    endcase
  end

  // Request latch: memory operands come only from here, so they stay frozen
  // from ACCESS entry until the next accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_is_write    <= 1'b0;
      lat_is_unsigned <= 1'b0;
      lat_op_size     <= '0;
      lat_addr        <= '0;
      lat_wdata       <= '0;
      lat_tag         <= '0;
    end else if (accept) begin
      lat_is_write    <= req_is_write;
      lat_is_unsigned <= req_is_unsigned;
      lat_op_size     <= req_op_size;
      lat_addr        <= agu_addr;
      lat_wdata       <= req_wdata;
      lat_tag         <= req_tag;
    end
  end

  // Response capture in SAMPLE; stores and faulting accesses return zero data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_data_q  <= '0;
      rsp_fault_q <= '0;
      rsp_tag_q   <= '0;
    end else if (sample) begin
      rsp_data_q  <= (lat_is_write || is_fault(mem_fault_num)) ? '0 : mem_out;
      rsp_fault_q <= mem_fault_num;
      rsp_tag_q   <= lat_tag;
    end
  end

`ifdef LSU_FAULT_ADDR_EN
  logic [31:0] rsp_fault_addr_q;

  // Faulting address for mtval, zero for clean accesses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_fault_addr_q <= '0;
    end else if (sample) begin
      rsp_fault_addr_q <= is_fault(mem_fault_num) ? lat_addr : '0;
    end
  end

  assign rsp_fault_addr = rsp_fault_addr_q;
`endif

  assign mem_is_write    = lat_is_write;
  assign mem_is_unsigned = lat_is_unsigned;
  assign mem_op_size     = lat_op_size;
  assign mem_addr        = lat_addr;
  assign mem_in          = lat_wdata;

  assign rsp_data      = rsp_data_q;
  assign rsp_fault_num = rsp_fault_q;
  assign rsp_tag       = rsp_tag_q;

endmodule

// File: tb/tb_load_store_sequencer.sv
// Directed self-checking bench for load_store_sequencer.
// Optional macro LSU_FAULT_ADDR_EN also checks rsp_fault_addr.
module tb_load_store_sequencer;

  localparam int unsigned TB_TAG_BITS = 5;

  logic                   clk;
  logic                   reset_n;
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_is_write;
  logic                   req_is_unsigned;
  logic [1:0]             req_op_size;
  logic [31:0]            req_base;
  logic [11:0]            req_offset;
  logic [31:0]            req_wdata;
  logic [TB_TAG_BITS-1:0] req_tag;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [31:0]            rsp_data;
  logic [TB_TAG_BITS-1:0] rsp_tag;
  logic [2:0]             rsp_fault_num;
`ifdef LSU_FAULT_ADDR_EN
  logic [31:0]            rsp_fault_addr;
`endif
  logic                   mem_enable_n;
  logic                   mem_is_write;
  logic                   mem_is_unsigned;
  logic [1:0]             mem_op_size;
  logic [31:0]            mem_addr;
  logic [31:0]            mem_in;
  logic [31:0]            mem_out;
  logic [2:0]             mem_fault_num;

  int unsigned total;
  int unsigned bad;

  load_store_sequencer #(.TAG_BITS(TB_TAG_BITS)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_is_write    (req_is_write),
    .req_is_unsigned (req_is_unsigned),
    .req_op_size     (req_op_size),
    .req_base        (req_base),
    .req_offset      (req_offset),
    .req_wdata       (req_wdata),
    .req_tag         (req_tag),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .rsp_tag         (rsp_tag),
    .rsp_fault_num   (rsp_fault_num),
`ifdef LSU_FAULT_ADDR_EN
    .rsp_fault_addr  (rsp_fault_addr),
`endif
    .mem_enable_n    (mem_enable_n),
    .mem_is_write    (mem_is_write),
    .mem_is_unsigned (mem_is_unsigned),
    .mem_op_size     (mem_op_size),
    .mem_addr        (mem_addr),
    .mem_in          (mem_in),
    .mem_out         (mem_out),
    .mem_fault_num   (mem_fault_num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One full transaction with hand-computed expectations; hold = cycles of
  // rsp_ready low in RESPOND, during which a stray request is offered.
  task automatic run_txn(
    input string       name,
    input logic        wr,
    input logic        uns,
    input logic [1:0]  size,
    input logic [31:0] base,
    input logic [11:0] off,
    input logic [31:0] wdata,
    input logic [4:0]  tag,
    input logic [31:0] m_out,
    input logic [2:0]  m_fault,
    input logic [31:0] exp_addr,
    input logic [31:0] exp_data,
    input logic [31:0] exp_fa,
    input int          hold
  );
    @(negedge clk);
    check({name, ".req_ready_idle"}, {31'd0, req_ready}, 32'd1);
    req_valid       = 1'b1;
    req_is_write    = wr;
    req_is_unsigned = uns;
    req_op_size     = size;
    req_base        = base;
    req_offset      = off;
    req_wdata       = wdata;
    req_tag         = tag;
    mem_out         = m_out;
    mem_fault_num   = m_fault;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_base   = 32'hFFFF_0000;
    req_offset = 12'h123;
    req_wdata  = 32'h0BAD_0BAD;
    @(negedge clk);
    check({name, ".acc_en_n"},   {31'd0, mem_enable_n}, 32'd0);
    check({name, ".acc_addr"},   mem_addr, exp_addr);
    check({name, ".acc_write"},  {31'd0, mem_is_write}, {31'd0, wr});
    check({name, ".acc_uns"},    {31'd0, mem_is_unsigned}, {31'd0, uns});
    check({name, ".acc_size"},   {30'd0, mem_op_size}, {30'd0, size});
    check({name, ".acc_in"},     mem_in, wdata);
    check({name, ".acc_ready"},  {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check({name, ".smp_en_n"},   {31'd0, mem_enable_n}, 32'd1);
    check({name, ".smp_addr"},   mem_addr, exp_addr);
    check({name, ".smp_in"},     mem_in, wdata);
    check({name, ".smp_valid"},  {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check({name, ".rsp_valid"},  {31'd0, rsp_valid}, 32'd1);
    check({name, ".rsp_data"},   rsp_data, exp_data);
    check({name, ".rsp_fault"},  {29'd0, rsp_fault_num}, {29'd0, m_fault});
    check({name, ".rsp_tag"},    {27'd0, rsp_tag}, {27'd0, tag});
`ifdef LSU_FAULT_ADDR_EN
    check({name, ".rsp_fa"},     rsp_fault_addr, exp_fa);
`else
    if (exp_fa === 32'hFFFF_FFFF) $display("note: unused fault addr");
`endif
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_tag   = 5'h1F;
      @(negedge clk);
      check({name, ".bp_valid"}, {31'd0, rsp_valid}, 32'd1);
      check({name, ".bp_ready"}, {31'd0, req_ready}, 32'd0);
      check({name, ".bp_data"},  rsp_data, exp_data);
      check({name, ".bp_tag"},   {27'd0, rsp_tag}, {27'd0, tag});
      check({name, ".bp_en_n"},  {31'd0, mem_enable_n}, 32'd1);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check({name, ".done_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({name, ".done_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    reset_n         = 1'b0;
    req_valid       = 1'b0;
    req_is_write    = 1'b0;
    req_is_unsigned = 1'b0;
    req_op_size     = 2'b00;
    req_base        = '0;
    req_offset      = '0;
    req_wdata       = '0;
    req_tag         = '0;
    rsp_ready       = 1'b0;
    mem_out         = '0;
    mem_fault_num   = '0;

    #3;
    check("rst.req_ready", {31'd0, req_ready}, 32'd1);
    check("rst.en_n",      {31'd0, mem_enable_n}, 32'd1);
    check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst.mem_addr",  mem_addr, 32'd0);
    check("rst.rsp_data",  rsp_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // name wr uns size base off wdata tag m_out m_fault exp_addr exp_data exp_fa hold
    run_txn("lw",      1'b0, 1'b0, 2'b10, 32'h2000_0000, 12'h010, 32'h0,         5'h03,
            32'hDEAD_BEEF, 3'b000, 32'h2000_0010, 32'hDEAD_BEEF, 32'h0,         0);
    run_txn("sh_mis",  1'b1, 1'b0, 2'b01, 32'h2000_0001, 12'h000, 32'h0000_BEEF, 5'h07,
            32'h1234_5678, 3'b110, 32'h2000_0001, 32'h0,         32'h2000_0001, 0);
    run_txn("lbu_neg", 1'b0, 1'b1, 2'b00, 32'h2000_0004, 12'hFFC, 32'h0,         5'h09,
            32'h0000_00FF, 3'b000, 32'h2000_0000, 32'h0000_00FF, 32'h0,         0);
    run_txn("wrap_bp", 1'b0, 1'b0, 2'b10, 32'hFFFF_FFFC, 12'h008, 32'h0,         5'h0C,
            32'hCAFE_F00D, 3'b000, 32'h0000_0004, 32'hCAFE_F00D, 32'h0,         5);
    run_txn("bad_sz",  1'b0, 1'b0, 2'b11, 32'h3000_0000, 12'h7FF, 32'h0,         5'h15,
            32'hAAAA_5555, 3'b100, 32'h3000_07FF, 32'h0,         32'h3000_07FF, 0);
    run_txn("ld_acc",  1'b0, 1'b0, 2'b10, 32'h0000_1000, 12'h800, 32'h0,         5'h16,
            32'h1111_2222, 3'b101, 32'h0000_0800, 32'h0,         32'h0000_0800, 0);
    run_txn("b2b_ld",  1'b0, 1'b0, 2'b10, 32'h2000_0000, 12'h000, 32'h0,         5'h11,
            32'h0102_0304, 3'b000, 32'h2000_0000, 32'h0102_0304, 32'h0,         0);
    run_txn("b2b_st",  1'b1, 1'b0, 2'b10, 32'h2000_0000, 12'h004, 32'h55AA_55AA, 5'h12,
            32'h0000_0077, 3'b000, 32'h2000_0004, 32'h0,         32'h0,         0);

    // Reset asserted while ACCESS is in progress.
    @(negedge clk);
    req_valid    = 1'b1;
    req_is_write = 1'b0;
    req_op_size  = 2'b10;
    req_base     = 32'h4000_0000;
    req_offset   = 12'h020;
    req_tag      = 5'h1A;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("abort.pre_en_n", {31'd0, mem_enable_n}, 32'd0);
    check("abort.pre_addr", mem_addr, 32'h4000_0020);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort.en_n",      {31'd0, mem_enable_n}, 32'd1);
    check("abort.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort.req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("abort.idle_ready", {31'd0, req_ready}, 32'd1);
    check("abort.idle_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort.idle_addr",  mem_addr, 32'd0);

    run_txn("post_rst", 1'b0, 1'b0, 2'b10, 32'h2000_0100, 12'h004, 32'h0,       5'h05,
            32'h600D_600D, 3'b000, 32'h2000_0104, 32'h600D_600D, 32'h0,         1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #50000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
